// File: rtl/contador16_pkg.sv
// contador16_pkg
// Shared definitions for the 16-bit cascaded counter checker:
//   - counter mode encodings as driven on modo
//   - checker state enum
//   - predict(): next-value / wrap predictor used by the reference model
// The predictor works on a PRED_W-bit container. Callers pass a mask
// of their real width so that one function serves any WIDTH < PRED_W.
package contador16_pkg;

    localparam logic [1:0] MODO_UP    = 2'b00;
    localparam logic [1:0] MODO_DOWN  = 2'b01;
    localparam logic [1:0] MODO_DOWN3 = 2'b10;
    localparam logic [1:0] MODO_LOAD  = 2'b11;

    localparam int PRED_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SYNC  = 2'b01,
        ST_CHECK = 2'b10
    } state_t;

    // Returns {rco, q}. q is the expected counter value one sample after
    // (prev_q, modo, enb); rco is the expected carry out of the top slice.
    // A disabled counter holds and never ripples; a load never ripples.
    function automatic logic [PRED_W:0] predict(
        input logic [PRED_W-1:0] prev_q,
        input logic [1:0]        modo,
        input logic              enb,
        input logic [PRED_W-1:0] prev_d,
        input logic [PRED_W-1:0] mask
    );
        logic [PRED_W-1:0] q;
        logic              rco;
        q   = prev_q;
        rco = 1'b0;
        if (enb) begin
            case (modo)
                MODO_UP: begin
                    q   = (prev_q + 32'd1) & mask;
                    rco = (prev_q == mask);
                end
                MODO_DOWN: begin
                    q   = (prev_q - 32'd1) & mask;
                    rco = (prev_q == '0);
                end
                MODO_DOWN3: begin
                    q   = (prev_q - 32'd3) & mask;
                    rco = (prev_q < 32'd3);
                end
                default: begin
                    q   = prev_d & mask;
                    rco = 1'b0;
                end
            endcase
        end
        return {rco, q};
    endfunction

endpackage

// File: rtl/contador16_model.sv
// contador16_model
// Reference model for the cascaded counter: registers the previous
// sample (Q, modo, D, enb) and combinationally predicts what the counter
// must show on the current sample.
// Ports:
//   clk, reset_L   sampling clock, asynchronous active-low reset
//   enb, modo, d   stimulus sampled this cycle
//   q              observed counter value sampled this cycle
//   prev_enb       enable of the previous sample
//   exp_q          predicted value for the current sample
//   exp_rco        predicted top-slice carry for the current sample
// prev_q always takes the observed Q, so after a mismatch the model is
// already re-seeded from what the counter actually shows: one bad sample
// produces exactly one error.
module contador16_model
    import contador16_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             enb,
    input  logic [1:0]       modo,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] q,
    output logic             prev_enb,
    output logic [WIDTH-1:0] exp_q,
    output logic             exp_rco
);

    logic [WIDTH-1:0]  prev_q;
    logic [WIDTH-1:0]  prev_d;
    logic [1:0]        prev_modo;
    logic [PRED_W:0]   pred;
    logic              pred_unused;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            prev_q    <= '0;
            prev_d    <= '0;
            prev_modo <= MODO_UP;
            prev_enb  <= 1'b0;
        end else begin
            prev_q    <= q;
            prev_d    <= d;
            prev_modo <= modo;
            prev_enb  <= enb;
        end
    end

    assign pred = predict(PRED_W'(prev_q), prev_modo, prev_enb,
                          PRED_W'(prev_d), PRED_W'({WIDTH{1'b1}}));

    assign exp_q       = pred[WIDTH-1:0];
    assign exp_rco     = pred[PRED_W];
    assign pred_unused = ^pred[PRED_W-1:WIDTH];

endmodule

// File: rtl/contador16_checker.sv
// contador16_checker
// Self-checking receiver for the 16-bit counter built from four 4-bit
// slices. Samples stimulus and response every rising edge, compares the
// response with the reference model and keeps error statistics.
// Ports:
//   clk, reset_L      sampling clock, asynchronous active-low reset
//   enb, modo, D      counter stimulus as driven to the slices
//   Q, RCO            counter response (only RCO[3] is checked)
//   clr_err           synchronous clear of fail, err_count, match_count
//   locked            high while comparing in CHECK
//   err               one-cycle pulse for a mismatching sample
//   fail              sticky mismatch flag
//   err_count         saturating mismatch count
//   match_count       saturating count of correct samples
//   exp_q             value predicted for the most recent sample
// Timing: the sample taken while leaving IDLE is the baseline; the next
// sample (closing the SYNC cycle) is the first one compared.
module contador16_checker
    import contador16_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter bit CHECK_RCO = 1'b1,
    parameter int ERRW      = 8
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             enb,
    input  logic [1:0]       modo,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] Q,
    input  logic [3:0]       RCO,
    input  logic             clr_err,
    output logic             locked,
    output logic             err,
    output logic             fail,
    output logic [ERRW-1:0]  err_count,
    output logic [15:0]      match_count,
    output logic [WIDTH-1:0] exp_q
);

    state_t           state;
    state_t           state_nxt;
    logic             do_cmp;
    logic             mismatch;
    logic             prev_enb;
    logic [WIDTH-1:0] pred_q;
    logic             pred_rco;
    logic             rco_unused;

    function automatic logic [ERRW-1:0] sat_inc_err(input logic [ERRW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [15:0] sat_inc_match(input logic [15:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction

    contador16_model #(
        .WIDTH(WIDTH)
    ) u_model (
        .clk      (clk),
        .reset_L  (reset_L),
        .enb      (enb),
        .modo     (modo),
        .d        (D),
        .q        (Q),
        .prev_enb (prev_enb),
        .exp_q    (pred_q),
        .exp_rco  (pred_rco)
    );

    assign rco_unused = ^RCO[2:0];

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // A single low enb sample inside CHECK is a legitimate hold; only two
    // consecutive low samples drop the lock.
    always_comb begin
        state_nxt = state;
        do_cmp    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enb) state_nxt = ST_SYNC;
            end
            ST_SYNC: begin
                if (enb) begin
                    do_cmp    = 1'b1;
                    state_nxt = ST_CHECK;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_CHECK: begin
                do_cmp = 1'b1;
                if (!enb && !prev_enb) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign mismatch = do_cmp &&
                      ((Q != pred_q) || (CHECK_RCO && (RCO[3] != pred_rco)));

    assign locked = (state == ST_CHECK);

    // Compare stage boundary: results registered with the sample edge.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            err         <= 1'b0;
            fail        <= 1'b0;
            err_count   <= '0;
            match_count <= '0;
            exp_q       <= '0;
        end else begin
            err   <= mismatch;
            exp_q <= pred_q;
            if (clr_err) begin
                fail        <= 1'b0;
                err_count   <= '0;
                match_count <= '0;
            end else if (mismatch) begin
                fail      <= 1'b1;
                err_count <= sat_inc_err(err_count);
            end else if (do_cmp) begin
                match_count <= sat_inc_match(match_count);
            end
        end
    end

endmodule

// File: tb/tb_contador16_checker.sv
module tb_contador16_checker;

    logic        clk = 1'b0;
    logic        reset_L;
    logic        enb;
    logic [1:0]  modo;
    logic [15:0] D;
    logic [15:0] Q;
    logic [3:0]  RCO;
    logic        clr_err;
    logic        locked;
    logic        err;
    logic        fail;
    logic [7:0]  err_count;
    logic [15:0] match_count;
    logic [15:0] exp_q;

    int checks   = 0;
    int failures = 0;

    // Behavioural reference: last sample plus arithmetic on plain ints.
    int m_prev_q, m_prev_d, m_prev_modo, m_prev_enb;
    int m_run;              // -1 idle, 0 baseline taken, 1 comparing
    int m_err, m_fail, m_ecnt, m_mcnt, m_expq, m_locked;

    contador16_checker #(
        .WIDTH(16), .CHECK_RCO(1'b1), .ERRW(8)
    ) dut (
        .clk(clk), .reset_L(reset_L), .enb(enb), .modo(modo), .D(D), .Q(Q),
        .RCO(RCO), .clr_err(clr_err), .locked(locked), .err(err), .fail(fail),
        .err_count(err_count), .match_count(match_count), .exp_q(exp_q)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_prev_q = 0; m_prev_d = 0; m_prev_modo = 0; m_prev_enb = 0;
        m_run = -1; m_err = 0; m_fail = 0; m_ecnt = 0; m_mcnt = 0;
        m_expq = 0; m_locked = 0;
    endtask

    // Value and wrap the counter must show on the next sample.
    task automatic model_pred(output int ev, output int erco);
        ev = m_prev_q;
        erco = 0;
        if (m_prev_enb != 0) begin
            case (m_prev_modo)
                0: begin ev = m_prev_q + 1; erco = (ev > 65535); end
                1: begin ev = m_prev_q - 1; erco = (ev < 0); end
                2: begin ev = m_prev_q - 3; erco = (ev < 0); end
                default: ev = m_prev_d;
            endcase
        end
        ev = (ev + 65536) % 65536;
    endtask

    task automatic step(input logic e, input logic [1:0] m, input logic [15:0] d,
                        input logic [15:0] q, input logic r3, input logic clr);
        int ev, erco, cmp, bad;
        enb = e; modo = m; D = d; Q = q; RCO = {r3, 3'b000}; clr_err = clr;
        @(posedge clk);
        model_pred(ev, erco);
        cmp = 0;
        if (m_run < 0) begin
            if (e) m_run = 0;
        end else if (m_run == 0) begin
            if (e) begin cmp = 1; m_run = 1; end
            else m_run = -1;
        end else begin
            cmp = 1;
            if (!e && m_prev_enb == 0) m_run = -1;
        end
        bad = cmp && ((int'(q) != ev) || (int'(r3) != erco));
        m_err = bad;
        if (clr) begin
            m_fail = 0; m_ecnt = 0; m_mcnt = 0;
        end else if (bad) begin
            m_fail = 1;
            if (m_ecnt < 255) m_ecnt++;
        end else if (cmp) begin
            if (m_mcnt < 65535) m_mcnt++;
        end
        m_expq = ev;
        m_locked = (m_run == 1);
        m_prev_q = int'(q); m_prev_d = int'(d); m_prev_modo = int'(m); m_prev_enb = int'(e);
        #1;
        chk("err", err, m_err);
        chk("fail", fail, m_fail);
        chk("err_count", err_count, m_ecnt);
        chk("match_count", match_count, m_mcnt);
        chk("locked", locked, m_locked);
        chk("exp_q", exp_q, m_expq);
    endtask

    // Drive a well-behaved counter response.
    task automatic good(input logic e, input logic [1:0] m, input logic [15:0] d, input logic clr);
        int ev, erco;
        model_pred(ev, erco);
        step(e, m, d, ev[15:0], erco[0], clr);
    endtask

    initial begin
        int ev, erco, e0;
        reset_L = 1'b0; enb = 0; modo = 0; D = 0; Q = 0; RCO = 0; clr_err = 0;
        model_reset();
        #2;
        chk("rst_locked", locked, 0);
        chk("rst_err", err, 0);
        chk("rst_fail", fail, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_match_count", match_count, 0);
        chk("rst_exp_q", exp_q, 0);
        #10 reset_L = 1'b1;

        // Count up 0..5: locks on the 2nd edge, 5 matches.
        for (int i = 0; i < 6; i++) good(1, 2'b00, 16'h0, 0);
        chk("up_matches", match_count, 5);
        chk("up_no_err", err_count, 0);

        // Up-wrap FFFF->0000 with carry (match), then without carry (error).
        good(1, 2'b11, 16'hFFFF, 0);
        good(1, 2'b00, 16'h0, 0);
        good(1, 2'b00, 16'h0, 0);
        chk("wrap_q", exp_q, 16'h0000);
        chk("wrap_rco_ok", err, 0);
        good(1, 2'b11, 16'hFFFF, 0);
        good(1, 2'b00, 16'h0, 0);
        step(1, 2'b00, 16'h0, 16'h0000, 1'b0, 0);
        chk("wrap_rco_bad_err", err, 1);
        chk("wrap_rco_bad_cnt", err_count, 1);

        // Down by 3 from 0x0002: 0xFFFF with carry, then 0xFFFC.
        good(1, 2'b11, 16'h0002, 0);
        good(1, 2'b10, 16'h0, 0);
        step(1, 2'b10, 16'h0, 16'hFFFF, 1'b1, 0);
        chk("down3_wrap", err, 0);
        step(1, 2'b10, 16'h0, 16'hFFFC, 1'b0, 0);
        chk("down3_next", err, 0);

        // Load 0xA5C3 then see it; inject 0xA5C2 once, expect one error only.
        good(1, 2'b11, 16'hA5C3, 0);
        step(1, 2'b00, 16'h0, 16'hA5C3, 1'b0, 0);
        chk("load_ok", err, 0);
        e0 = m_ecnt;
        good(1, 2'b11, 16'hA5C3, 0);
        step(1, 2'b00, 16'h0, 16'hA5C2, 1'b0, 0);
        chk("inject_err", err, 1);
        for (int i = 0; i < 4; i++) good(1, 2'b01, 16'h0, 0);
        chk("inject_single", err_count, e0 + 1);

        // One low enb sample holds; two drop the lock.
        good(0, 2'b00, 16'h0, 0);
        good(1, 2'b00, 16'h0, 0);
        chk("hold_locked", locked, 1);
        good(0, 2'b00, 16'h0, 0);
        good(0, 2'b00, 16'h0, 0);
        chk("idle_unlocked", locked, 0);
        good(1, 2'b00, 16'h0, 0);
        good(1, 2'b00, 16'h0, 1);

        // 300 forced mismatches saturate err_count at 255.
        for (int i = 0; i < 300; i++) begin
            model_pred(ev, erco);
            step(1, 2'b00, 16'h0, ev[15:0] ^ 16'h0001, erco[0], 0);
        end
        chk("sat_err_count", err_count, 255);
        chk("sat_fail", fail, 1);
        model_pred(ev, erco);
        step(1, 2'b00, 16'h0, ev[15:0] ^ 16'h0001, erco[0], 1);
        chk("clr_err_pulse", err, 1);
        chk("clr_err_count", err_count, 0);
        chk("clr_fail", fail, 0);

        // Randomised traffic with occasional faults and clears.
        for (int i = 0; i < 300; i++) begin
            logic e;
            logic [1:0] m;
            logic [15:0] d, q;
            logic r3;
            e = ($urandom_range(0, 9) != 0);
            m = 2'($urandom_range(0, 3));
            d = 16'($urandom);
            model_pred(ev, erco);
            q = ev[15:0];
            r3 = erco[0];
            if ($urandom_range(0, 19) == 0) q = q ^ (16'h1 << $urandom_range(0, 15));
            if ($urandom_range(0, 39) == 0) r3 = ~r3;
            step(e, m, d, q, r3, ($urandom_range(0, 49) == 0));
        end

        // Asynchronous reset mid-CHECK.
        good(1, 2'b00, 16'h0, 0);
        good(1, 2'b00, 16'h0, 0);
        good(1, 2'b00, 16'h0, 0);
        @(negedge clk);
        reset_L = 1'b0;
        #1;
        chk("mid_rst_locked", locked, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_fail", fail, 0);
        chk("mid_rst_err_count", err_count, 0);
        chk("mid_rst_match_count", match_count, 0);
        chk("mid_rst_exp_q", exp_q, 0);
        model_reset();
        @(negedge clk);
        reset_L = 1'b1;
        step(1, 2'b00, 16'h0, 16'h1234, 1'b0, 0);
        chk("post_rst_first", match_count, 0);
        chk("post_rst_first_err", err, 0);
        good(1, 2'b00, 16'h0, 0);
        chk("post_rst_second", match_count, 1);
        chk("post_rst_locked", locked, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
